// File: rtl/data_mem_responder.sv
// Single-port data memory responder with a fixed wait-state latency and a valid/ready handshake.
// Optional byte-lane write enables are compiled in with `define DATA_MEM_BYTE_EN_EN.
module data_mem_responder #(
    parameter int unsigned n           = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    input  logic [3:0]   req_be,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [n-1:0] resp_rdata,
    output logic         resp_err,
    output logic         busy
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         wr_q, wr_d;
    logic [n-1:0] addr_q, addr_d;
    logic [n-1:0] wdata_q, wdata_d;
    logic         req_ready_q, req_ready_d;
    logic         resp_valid_q, resp_valid_d;
    logic [n-1:0] rdata_q, rdata_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;

    logic [n-1:0] mem_q [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          mem_we;
    logic          cur_write;
    logic [n-1:0]  cur_addr;
    logic [n-1:0]  cur_wdata;
    logic          cur_err;
    logic [AW-1:0] cur_idx;
    logic [n-1:0]  wmask;

`ifdef DATA_MEM_BYTE_EN_EN
    logic [3:0] be_q, be_d;
    logic [3:0] cur_be;
`else
    logic       unused_be;
    assign unused_be = ^req_be;
`endif

    assign accept = (state_q == S_IDLE) && req_ready_q && req_valid;

    // With zero wait states the request is executed on the accepting edge, so use the live inputs.
    always_comb begin
        cur_write = wr_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
`ifdef DATA_MEM_BYTE_EN_EN
        cur_be    = be_q;
`endif
        if (state_q == S_IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
`ifdef DATA_MEM_BYTE_EN_EN
            cur_be    = req_be;
`endif
        end
    end

    assign cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> 2) >= n'(DEPTH));
    assign cur_idx = cur_addr[AW+1:2];

    always_comb begin
        wmask = '0;
`ifdef DATA_MEM_BYTE_EN_EN
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{cur_be[i]}};
        end
`else
        wmask = '1;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef DATA_MEM_BYTE_EN_EN
        be_d       = be_q;
`endif
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
`ifdef DATA_MEM_BYTE_EN_EN
                    be_d    = req_be;
`endif
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        rdata_d      = rdata_q;
        err_d        = err_q;
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_write) ? '0 : mem_q[cur_idx];
        end else if (state_d != S_RESP) begin
            err_d   = 1'b0;
            rdata_d = '0;
        end
    end

    assign mem_we = enter_resp && cur_write && !cur_err;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef DATA_MEM_BYTE_EN_EN
            be_q         <= 4'd0;
`endif
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef DATA_MEM_BYTE_EN_EN
            be_q         <= be_d;
`endif
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Storage array keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[cur_idx] <= (mem_q[cur_idx] & ~wmask) | (cur_wdata & wmask);
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array reference model.
// Two instances: one with two wait states, one with none.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;

    logic        CLK = 1'b0;
    logic        rst;

    logic        v0, rdy0, wr0, rv0, rr0, er0, busy0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  be0;

    logic        v1, rdy1, wr1, rv1, rr1, er1, busy1;
    logic [31:0] addr1, wd1, rd1;
    logic [3:0]  be1;

    logic [31:0] ref_mem0 [DEPTH];
    logic [31:0] ref_mem1 [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    data_mem_responder #(.n(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
        .CLK(CLK), .rst(rst),
        .req_valid(v0), .req_ready(rdy0), .req_write(wr0), .req_addr(addr0),
        .req_wdata(wd0), .req_be(be0),
        .resp_valid(rv0), .resp_ready(rr0), .resp_rdata(rd0), .resp_err(er0),
        .busy(busy0)
    );

    data_mem_responder #(.n(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
        .CLK(CLK), .rst(rst),
        .req_valid(v1), .req_ready(rdy1), .req_write(wr1), .req_addr(addr1),
        .req_wdata(wd1), .req_be(be1),
        .resp_valid(rv1), .resp_ready(rr1), .resp_rdata(rd1), .resp_err(er1),
        .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    // Word after a store: only enabled lanes change when byte enables are built in.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        logic [3:0]  lanes;
`ifdef DATA_MEM_BYTE_EN_EN
        lanes = be;
`else
        lanes = 4'hF | be;
`endif
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // One full transaction on the two-wait-state instance; called at a falling edge.
    task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold);
        int          lat;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = addr_bad(a);
        exp_rd  = 32'd0;
        idx     = int'(a / 4);
        if (!exp_err) begin
            if (w) ref_mem0[idx] = merge(ref_mem0[idx], d, be);
            else   exp_rd = ref_mem0[idx];
        end
        lat = 0;
        while (!rdy0 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("req_ready_before_accept", 32'(rdy0), 32'd1);
        v0 = 1'b1; wr0 = w; addr0 = a; wd0 = d; be0 = be;
        @(posedge CLK);
        #1;
        v0 = 1'b0; wr0 = 1'($urandom); addr0 = $urandom; wd0 = $urandom; be0 = 4'($urandom);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (!rv0) rr0 = 1'($urandom);
        end while (!rv0 && lat < 20);
        rr0 = 1'b0;
        check("resp_latency", 32'(lat), 32'd3);
        check("resp_rdata", rd0, exp_rd);
        check("resp_err", 32'(er0), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            v0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0; wd0 = $urandom; be0 = 4'hF;
            @(negedge CLK);
            check("hold_valid", 32'(rv0), 32'd1);
            check("hold_rdata", rd0, exp_rd);
            check("hold_err", 32'(er0), 32'(exp_err));
            check("hold_req_ready", 32'(rdy0), 32'd0);
            check("hold_busy", 32'(busy0), 32'd1);
        end
        v0 = 1'b0;
        rr0 = 1'b1;
        @(posedge CLK);
        #1;
        rr0 = 1'b0;
        @(negedge CLK);
        check("post_resp_valid", 32'(rv0), 32'd0);
        check("post_resp_ready", 32'(rdy0), 32'd1);
        check("post_resp_busy", 32'(busy0), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] snap;
        int          r;
        int          lat;
        rst = 1'b0;
        v0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0; be0 = '0; rr0 = 1'b0;
        v1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0; be1 = '0; rr1 = 1'b0;
        #1;
        check("reset_req_ready", 32'(rdy0), 32'd0);
        check("reset_resp_valid", 32'(rv0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_rdata", rd0, 32'd0);
        repeat (3) @(negedge CLK);
        rst = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(rdy0), 32'd0);
        @(negedge CLK);
        check("ready_after_first_edge", 32'(rdy0), 32'd1);
        check("ready_after_first_edge_w0", 32'(rdy1), 32'd1);

        // Give every word a known value so loads can be checked anywhere.
        for (int i = 0; i < DEPTH; i++) txn0(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        // Store then load back.
        txn0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn0(1'b0, 32'h10, 32'h0, 4'hF, 0);
        check("deadbeef_readback", ref_mem0[4], 32'hDEADBEEF);

        // Misaligned and out-of-range accesses.
        txn0(1'b0, 32'h13, 32'h0, 4'hF, 0);
        txn0(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 0);
        txn0(1'b1, 32'h13, 32'hCAFEF00D, 4'hF, 0);
        txn0(1'b0, 32'h10, 32'h0, 4'hF, 0);

        // Long response stall.
        txn0(1'b0, 32'h10, 32'h0, 4'hF, 5);

        // Partial-lane store.
        txn0(1'b1, 32'h0, 32'h11223344, 4'hF, 0);
        txn0(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 1);
        txn0(1'b0, 32'h0, 32'h0, 4'hF, 0);
`ifdef DATA_MEM_BYTE_EN_EN
        check("byte_lane_merge", ref_mem0[0], 32'h11BB33DD);
`else
        check("byte_lane_merge", ref_mem0[0], 32'hAABBCCDD);
`endif

        // Reset in the middle of a store's wait states.
        snap = ref_mem0[8];
        v0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; wd0 = 32'h12345678; be0 = 4'hF;
        @(posedge CLK);
        #1;
        v0 = 1'b0;
        @(negedge CLK);
        check("busy_in_wait", 32'(busy0), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy0), 32'd0);
        check("async_rst_req_ready", 32'(rdy0), 32'd0);
        check("async_rst_resp_valid", 32'(rv0), 32'd0);
        check("async_rst_rdata", rd0, 32'd0);
        check("async_rst_err", 32'(er0), 32'd0);
        repeat (2) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        check("ready_after_rst", 32'(rdy0), 32'd1);
        txn0(1'b0, 32'h20, 32'h0, 4'hF, 0);
        check("aborted_store_model", ref_mem0[8], snap);

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1023)) << 2);
            else if (r == 2) a = $urandom | 32'h8000_0000;
            else             a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            txn0(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        // Zero-wait instance: back-to-back with the consumer always ready.
        rr1 = 1'b1;
        lat = 0;
        while (!rdy1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        for (int j = 0; j < 9; j++) begin
            logic [31:0] exp_rd;
            logic        exp_err;
            check("w0_req_ready_even", 32'(rdy1), 32'd1);
            check("w0_resp_valid_even", 32'(rv1), 32'd0);
            if (j < 4) begin
                wr1 = 1'b1; addr1 = 32'h40 + 32'(4 * j); wd1 = $urandom;
            end else if (j < 8) begin
                wr1 = 1'b0; addr1 = 32'h40 + 32'(4 * (j - 4)); wd1 = $urandom;
            end else begin
                wr1 = 1'b0; addr1 = 32'h41; wd1 = $urandom;
            end
            be1 = 4'hF;
            v1  = 1'b1;
            exp_err = addr_bad(addr1);
            exp_rd  = 32'd0;
            if (!exp_err) begin
                if (wr1) ref_mem1[addr1 / 4] = merge(ref_mem1[addr1 / 4], wd1, be1);
                else     exp_rd = ref_mem1[addr1 / 4];
            end
            @(negedge CLK);
            v1 = 1'b0;
            check("w0_resp_valid_odd", 32'(rv1), 32'd1);
            check("w0_req_ready_odd", 32'(rdy1), 32'd0);
            check("w0_rdata", rd1, exp_rd);
            check("w0_err", 32'(er1), 32'(exp_err));
            @(negedge CLK);
        end
        rr1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter n, 32, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, 256, number of n-bit words stored.
REQ-003 SHALL have parameter WAIT_CYCLES, 2, wait states inserted between request accept and response (0..15).
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  CPU presents a load/store request.
REQ-007 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  n  byte address.
REQ-010 SHALL have port req_wdata  input  n  store data.
REQ-011 SHALL have port req_be  input  4  byte enables, bit i = byte lane i (used only per REQ-032).
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  CPU consumes the response.
REQ-014 SHALL have port resp_rdata  output  n  load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  misaligned or out-of-range access.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; request accepted on an edge where req_valid & req_ready.
REQ-019 SHALL latch req_write, req_addr, req_wdata, req_be on acceptance; inputs ignored in any other cycle.
REQ-020 SHALL transition IDLE->WAIT on acceptance when WAIT_CYCLES>0, IDLE->RESP when WAIT_CYCLES=0.
REQ-021 SHALL load a wait counter with WAIT_CYCLES-1 on entry to WAIT, decrement each cycle, go WAIT->RESP on the edge where counter is 0.
REQ-022 SHALL assert resp_valid exactly WAIT_CYCLES+1 cycles after the accepting edge, held with resp_rdata/resp_err stable until resp_ready.
REQ-023 SHALL go RESP->IDLE on the edge where resp_valid & resp_ready; resp_ready outside RESP is ignored.
REQ-024 SHALL use word index req_addr[log2(DEPTH)+1:2]; flag error when req_addr[1:0]!=0 or req_addr>>2 >= DEPTH.
REQ-025 SHALL commit a store to memory on the edge entering RESP, only when no error.
REQ-026 SHALL register load data on the edge entering RESP; a load following a store to the same word returns the stored value.
REQ-027 SHALL on error: suppress write, resp_rdata=0, resp_err=1.
REQ-028 SHALL allow a new acceptance the cycle after the RESP handshake; minimum transaction spacing WAIT_CYCLES+2 cycles.

Reset
REQ-029 SHALL on rst=0, immediately and regardless of clock: state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0; req_ready rises to 1 on the first edge after rst deasserts.
REQ-030 SHALL abort any in-flight transaction on reset with no memory write; memory array contents are not cleared by reset.

Configuration
REQ-031 SHALL compile byte-enable support under macro DATA_MEM_BYTE_EN_EN.
REQ-032 SHALL with DATA_MEM_BYTE_EN_EN defined: store writes only lanes with req_be[i]=1; req_be=0 makes a no-op store with normal response.
REQ-033 SHALL without DATA_MEM_BYTE_EN_EN: ignore req_be, every store writes all 4 bytes.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=2, store 0xDEADBEEF @0x10, then load @0x10 -> resp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-035 SHALL cover: load @0x13 and load @(DEPTH*4) -> resp_err=1, rdata=0; store @0x13 leaves word 0x10 unchanged.
REQ-036 SHALL cover: resp_ready held low 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0, no second request accepted.
REQ-037 SHALL cover: rst pulsed low during WAIT of store 0x12345678 @0x20 -> outputs zero asynchronously, later load @0x20 returns prior contents.
REQ-038 SHALL cover: DATA_MEM_BYTE_EN_EN defined, word 0x11223344 @0x0, store 0xAABBCCDD be=4'b0101 -> load returns 0x11BB33DD; undefined -> 0xAABBCCDD.
REQ-039 SHALL cover: WAIT_CYCLES=0, back-to-back requests with resp_ready=1 -> resp_valid 1 cycle after accept, accept every 2 cycles.
